// File: rtl/bpsk_tx_sequencer.sv
// bpsk_tx_sequencer
//
// Frame sequencer for the BPSK modulator. A rising edge on start (while idle)
// latches data_in and sends one frame: an alternating preamble starting with 1,
// the payload MSB-first, then an even-parity bit. Each symbol lasts
// SYMBOL_CYCLES clocks. A silent guard interval of GUARD_CYCLES clocks follows,
// and the frame ends with a one-cycle done pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      frame request, accepted on its rising edge while idle
//   data_in    payload, sampled on the accept cycle
//   tx_bit     current symbol bit to the modulator (0 outside a frame)
//   tx_valid   high while a symbol is being transmitted
//   sym_strobe one-cycle pulse on the first cycle of each symbol
//   busy       high from the cycle after accept through the end of the guard
//   done       one-cycle pulse when the frame completes
module bpsk_tx_sequencer #(
  parameter int unsigned SYMBOL_CYCLES = 250,
  parameter int unsigned PREAMBLE_LEN  = 8,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned GUARD_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              sym_strobe,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SymW   = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int unsigned IdxMax = (PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W;
  localparam int unsigned IdxW   = (IdxMax > 1) ? $clog2(IdxMax) : 1;
  localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [SymW-1:0]   SymLast   = SymW'(SYMBOL_CYCLES - 1);
  localparam logic [IdxW-1:0]   PreLast   = IdxW'(PREAMBLE_LEN - 1);
  localparam logic [IdxW-1:0]   DataLast  = IdxW'(DATA_W - 1);
  localparam logic [GuardW-1:0] GuardLast = GuardW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StData,
    StParity,
    StGuard
  } state_e;

  state_e              state_q, state_d;
  logic [SymW-1:0]     sym_cnt_q, sym_cnt_d;
  logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
  logic [GuardW-1:0]   guard_cnt_q, guard_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                parity_q, parity_d;
  logic                start_d_q;

  logic tx_bit_q, tx_bit_d;
  logic tx_valid_q, tx_valid_d;
  logic sym_strobe_q, sym_strobe_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic accept;
  logic sym_last;

  assign accept   = start & ~start_d_q & (state_q == StIdle);
  assign sym_last = (sym_cnt_q == SymLast);

  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    bit_idx_d    = bit_idx_q;
    guard_cnt_d  = guard_cnt_q;
    data_d       = data_q;
    parity_d     = parity_q;
    tx_bit_d     = tx_bit_q;
    tx_valid_d   = tx_valid_q;
    sym_strobe_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_bit_d   = 1'b0;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        if (accept) begin
          state_d      = StPreamble;
          data_d       = data_in;
          parity_d     = ^data_in;
          sym_cnt_d    = '0;
          bit_idx_d    = '0;
          tx_bit_d     = 1'b1;
          tx_valid_d   = 1'b1;
          sym_strobe_d = 1'b1;
          busy_d       = 1'b1;
        end
      end

      StPreamble, StData, StParity: begin
        if (!sym_last) begin
          sym_cnt_d = sym_cnt_q + SymW'(1);
        end else begin
          sym_cnt_d    = '0;
          sym_strobe_d = 1'b1;
          if (state_q == StPreamble) begin
            if (bit_idx_q == PreLast) begin
              // Payload is shifted out of the top of the latch, MSB first.
              state_d   = StData;
              bit_idx_d = '0;
              tx_bit_d  = data_q[DATA_W-1];
              data_d    = data_q << 1;
            end else begin
              bit_idx_d = bit_idx_q + IdxW'(1);
              // Next preamble index is even exactly when the current one is odd.
              tx_bit_d  = bit_idx_q[0];
            end
          end else if (state_q == StData) begin
            if (bit_idx_q == DataLast) begin
              state_d   = StParity;
              bit_idx_d = '0;
              tx_bit_d  = parity_q;
            end else begin
              bit_idx_d = bit_idx_q + IdxW'(1);
              tx_bit_d  = data_q[DATA_W-1];
              data_d    = data_q << 1;
            end
          end else begin
            state_d      = StGuard;
            guard_cnt_d  = '0;
            tx_bit_d     = 1'b0;
            tx_valid_d   = 1'b0;
            sym_strobe_d = 1'b0;
          end
        end
      end

      StGuard: begin
        if (guard_cnt_q == GuardLast) begin
          state_d     = StIdle;
          guard_cnt_d = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          guard_cnt_d = guard_cnt_q + GuardW'(1);
        end
      end

      default: begin
        state_d    = StIdle;
        tx_bit_d   = 1'b0;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sym_cnt_q    <= '0;
      bit_idx_q    <= '0;
      guard_cnt_q  <= '0;
      data_q       <= '0;
      parity_q     <= 1'b0;
      start_d_q    <= 1'b0;
      tx_bit_q     <= 1'b0;
      tx_valid_q   <= 1'b0;
      sym_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      bit_idx_q    <= bit_idx_d;
      guard_cnt_q  <= guard_cnt_d;
      data_q       <= data_d;
      parity_q     <= parity_d;
      start_d_q    <= start;
      tx_bit_q     <= tx_bit_d;
      tx_valid_q   <= tx_valid_d;
      sym_strobe_q <= sym_strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tx_bit     = tx_bit_q;
  assign tx_valid   = tx_valid_q;
  assign sym_strobe = sym_strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bpsk_tx_sequencer.sv
// Testbench for bpsk_tx_sequencer: table of frames, hand-written corner
// sequences and randomized stimulus, all checked cycle by cycle against a
// frame-offset reference model.
module tb_bpsk_tx_sequencer;

  localparam int SC  = 4;
  localparam int PL  = 4;
  localparam int DW  = 8;
  localparam int GC  = 3;
  localparam int NSYM     = PL + DW + 1;
  localparam int TXC      = NSYM * SC;
  localparam int DONE_OFF = TXC + GC + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] data_in;
  logic          tx_bit, tx_valid, sym_strobe, busy, done;

  int checks = 0;
  int passes = 0;

  // Reference model state: offset of the current cycle from the accept edge.
  bit            m_active = 1'b0;
  int            m_off    = 0;
  logic [DW-1:0] m_data   = '0;
  logic          m_prev   = 1'b0;

  bpsk_tx_sequencer #(
    .SYMBOL_CYCLES(SC),
    .PREAMBLE_LEN (PL),
    .DATA_W       (DW),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .tx_bit    (tx_bit),
    .tx_valid  (tx_valid),
    .sym_strobe(sym_strobe),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
  endtask

  function automatic logic [4:0] model_out();
    int sym;
    logic b;
    if (!rst_n || !m_active) return 5'b0;
    if (m_off <= TXC) begin
      sym = (m_off - 1) / SC;
      if (sym < PL) b = (sym % 2 == 0);
      else if (sym < PL + DW) b = m_data[DW-1-(sym-PL)];
      else b = ^m_data;
      return {b, 1'b1, ((m_off - 1) % SC == 0), 1'b1, 1'b0};
    end
    if (m_off <= TXC + GC) return 5'b00010;
    return 5'b00001;
  endfunction

  task automatic model_edge();
    bit idle;
    if (!rst_n) begin
      m_active = 1'b0;
      m_prev   = 1'b0;
      return;
    end
    idle = !m_active || (m_off == DONE_OFF);
    if (idle && start && !m_prev) begin
      m_active = 1'b1;
      m_off    = 1;
      m_data   = data_in;
    end else if (m_active) begin
      if (m_off == DONE_OFF) m_active = 1'b0;
      else m_off++;
    end
    m_prev = start;
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cycle_outputs", {27'd0, tx_bit, tx_valid, sym_strobe, busy, done}, {27'd0, model_out()});
  endtask

  // Sends one frame starting at the current falling edge; returns at the done cycle.
  task automatic run_frame(input logic [DW-1:0] d, input logic [DW-1:0] late,
                           input logic [NSYM-1:0] exp_syms, input string name);
    logic [NSYM-1:0] syms;
    int nstr, nval, done_at;
    syms = '0; nstr = 0; nval = 0; done_at = 0;
    data_in = d;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check({name, "_first_symbol"}, {29'd0, tx_valid, tx_bit, sym_strobe}, 32'd7);
    for (int c = 1; c <= DONE_OFF; c++) begin
      if (c == 10) data_in = late;
      if (sym_strobe) begin
        syms = {syms[NSYM-2:0], tx_bit};
        nstr++;
      end
      if (tx_valid) nval++;
      if (done) done_at = c;
      if (c < DONE_OFF) tick();
    end
    check({name, "_symbols"}, {19'd0, syms}, {19'd0, exp_syms});
    check({name, "_strobes"}, nstr, NSYM);
    check({name, "_valid_cycles"}, nval, TXC);
    check({name, "_done_cycle"}, done_at, DONE_OFF);
  endtask

  typedef struct {
    logic [DW-1:0]   data;
    logic [DW-1:0]   late;
    logic [NSYM-1:0] syms;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int done_cnt, frames;
    logic v_prev;

    tbl[0] = '{8'hA5, 8'hA5, {4'b1010, 8'hA5, 1'b0}};
    tbl[1] = '{8'h07, 8'h07, {4'b1010, 8'h07, 1'b1}};
    tbl[2] = '{8'h00, 8'hFF, {4'b1010, 8'h00, 1'b0}};
    tbl[3] = '{8'hFF, 8'h00, {4'b1010, 8'hFF, 1'b0}};
    tbl[4] = '{8'h80, 8'h13, {4'b1010, 8'h80, 1'b1}};

    rst_n = 1'b0; start = 1'b0; data_in = '0;
    tick();
    tick();
    check("reset_outputs", {27'd0, tx_bit, tx_valid, sym_strobe, busy, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table frames, sent back to back: each accept lands on the previous done cycle.
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].data, tbl[i].late, tbl[i].syms, $sformatf("table%0d", i));
    end
    tick();
    tick();

    // Held-high start with a second rising edge mid-frame: exactly one frame.
    done_cnt = 0; frames = 0; v_prev = 1'b0;
    data_in = 8'h3C;
    start   = 1'b1;
    tick();
    for (int c = 1; c <= 100; c++) begin
      if (c == 29) start = 1'b0;
      if (c == 30) start = 1'b1;
      if (done) done_cnt++;
      if (tx_valid && !v_prev) frames++;
      v_prev = tx_valid;
      tick();
    end
    start = 1'b0;
    check("held_start_done_count", done_cnt, 1);
    check("held_start_frames", frames, 1);
    tick();

    // Reset mid-frame: outputs drop at once and no done appears.
    done_cnt = 0;
    data_in = 8'h5A;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (done) done_cnt++;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {27'd0, tx_bit, tx_valid, sym_strobe, busy, done}, 32'd0);
    tick();
    if (done) done_cnt++;
    tick();
    if (done) done_cnt++;
    check("reset_no_done", done_cnt, 0);
    rst_n = 1'b1;
    tick();
    run_frame(8'h5A, 8'h5A, {4'b1010, 8'h5A, 1'b0}, "after_reset");

    // Back-to-back accept exactly on the done cycle.
    run_frame(8'hC3, 8'hC3, {4'b1010, 8'hC3, 1'b0}, "back_to_back");
    tick();

    // Randomized stimulus against the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) == 0) start = ~start;
      data_in = DW'($urandom);
      if (rst_n == 1'b0) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
